rop3_seq: RTL and testbench

- Sequencer that runs one ROP3 raster operation over a block of pixel words.
- Accepts a command: mode, source/pattern/destination base addresses, length.
- Streams P/S/D words out of three single-port SRAMs and pushes them through an internal registered ROP3 LUT core.
- Writes each result back to the destination SRAM. Sits between the host command register file and the ROP3 datapath.

---
 rtl/rop3_pkg.sv | 56 +++++
 rtl/rop3_core.sv | 50 +++++
 rtl/rop3_seq.sv | 144 ++++++++++++++
 tb/tb_rop3_seq.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rop3_pkg.sv
// Shared definitions for the ROP3 sequencer: supported mode codes, the
// sequencer FSM state type and the per-bit ROP3 function.
package rop3_pkg;

  localparam logic [7:0] ROP_ZERO        = 8'h00;
  localparam logic [7:0] ROP_NOR_DS      = 8'h11;
  localparam logic [7:0] ROP_NOT_S       = 8'h33;
  localparam logic [7:0] ROP_S_ANDN_D    = 8'h44;
  localparam logic [7:0] ROP_NOT_D       = 8'h55;
  localparam logic [7:0] ROP_D_XOR_P     = 8'h5A;
  localparam logic [7:0] ROP_D_XOR_S     = 8'h66;
  localparam logic [7:0] ROP_D_AND_S     = 8'h88;
  localparam logic [7:0] ROP_D_OR_NS     = 8'hBB;
  localparam logic [7:0] ROP_P_AND_S     = 8'hC0;
  localparam logic [7:0] ROP_S           = 8'hCC;
  localparam logic [7:0] ROP_D_OR_S      = 8'hEE;
  localparam logic [7:0] ROP_P           = 8'hF0;
  localparam logic [7:0] ROP_D_OR_P_OR_NS = 8'hFB;
  localparam logic [7:0] ROP_ONE         = 8'hFF;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  // True for the 15 codes the datapath implements.
  function automatic logic rop3_supported(input logic [7:0] mode);
    case (mode)
      ROP_ZERO, ROP_NOR_DS, ROP_NOT_S, ROP_S_ANDN_D, ROP_NOT_D,
      ROP_D_XOR_P, ROP_D_XOR_S, ROP_D_AND_S, ROP_D_OR_NS, ROP_P_AND_S,
      ROP_S, ROP_D_OR_S, ROP_P, ROP_D_OR_P_OR_NS, ROP_ONE: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

  // One result bit from one P/S/D bit; unsupported codes yield 0.
  function automatic logic rop3_fn(input logic [7:0] mode,
                                   input logic p, input logic s, input logic d);
    case (mode)
      ROP_ZERO:         return 1'b0;
      ROP_NOR_DS:       return ~(d | s);
      ROP_NOT_S:        return ~s;
      ROP_S_ANDN_D:     return s & ~d;
      ROP_NOT_D:        return ~d;
      ROP_D_XOR_P:      return d ^ p;
      ROP_D_XOR_S:      return d ^ s;
      ROP_D_AND_S:      return d & s;
      ROP_D_OR_NS:      return d | ~s;
      ROP_P_AND_S:      return p & s;
      ROP_S:            return s;
      ROP_D_OR_S:       return d | s;
      ROP_P:            return p;
      ROP_D_OR_P_OR_NS: return d | p | ~s;
      ROP_ONE:          return 1'b1;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rop3_core.sv
// ROP3 datapath: P/S/D input registers followed by a registered result.
module rop3_core
  import rop3_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_en,
  input  logic         res_en,
  input  logic [7:0]   mode,
  input  logic [N-1:0] p_in,
  input  logic [N-1:0] s_in,
  input  logic [N-1:0] d_in,
  output logic [N-1:0] result
);

  logic [N-1:0] p_q, s_q, d_q;
  logic [N-1:0] res_nxt;

  // Capture SRAM read data when a word is in the first pipe stage.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking so every flop samples pre-edge values, independent of statement order.
    if (rst) begin
      p_q <= '0;
      s_q <= '0;
      d_q <= '0;
    end else if (in_en) begin
      p_q <= p_in;
      s_q <= s_in;
      d_q <= d_in;
    end
  end

  // Apply the raster operation bit by bit.
  always_comb begin
    // NOTE: default first so no path leaves res_nxt unassigned and infers a latch.
    res_nxt = '0;
    for (int i = 0; i < N; i++) begin
      res_nxt[i] = rop3_fn(mode, p_q[i], s_q[i], d_q[i]);
    end
  end

  // Result register feeding the write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         result <= '0;
    else if (res_en) result <= res_nxt;
  end

endmodule

// File: rtl/rop3_seq.sv
// ROP3 block sequencer: reads P/S/D words, runs them through rop3_core and
// writes results back to the destination SRAM, len words per command.
// Optional: define ROP3_MODE_CHECK_EN to reject unsupported modes at start
// and report them on the err port.
module rop3_seq
  import rop3_pkg::*;
#(
  parameter int N  = 4,
  parameter int AW = 8,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    mode,
  input  logic [AW-1:0] p_base,
  input  logic [AW-1:0] s_base,
  input  logic [AW-1:0] d_base,
  input  logic [LW-1:0] len,
  input  logic          pause,
  output logic          rd_en,
  output logic [AW-1:0] p_addr,
  output logic [AW-1:0] s_addr,
  output logic [AW-1:0] d_raddr,
  input  logic [N-1:0]  p_rdata,
  input  logic [N-1:0]  s_rdata,
  input  logic [N-1:0]  d_rdata,
  output logic          wr_en,
  output logic [AW-1:0] d_waddr,
  output logic [N-1:0]  wr_data,
  output logic          busy,
  output logic          done
`ifdef ROP3_MODE_CHECK_EN
  ,
  output logic          err
`endif
);

  state_t              state, state_nxt;
  logic [7:0]          mode_q;
  logic [AW-1:0]       p_base_q, s_base_q, d_base_q;
  logic [LW-1:0]       len_q, rd_idx, wr_cnt;
  logic [2:0]          vld;
  logic [2:0][AW-1:0]  waddr_pipe;
  logic                accept, mode_bad, rd_last, wr_last;

  assign accept  = (state == IDLE) && start;
  assign rd_last = (rd_idx == len_q - LW'(1));
  // The write happening this cycle counts, so FIN follows the last write directly.
  assign wr_last = ((wr_cnt + LW'(wr_en)) == len_q);

`ifdef ROP3_MODE_CHECK_EN
  logic err_q;
  assign mode_bad = !rop3_supported(mode);
  assign err      = done && err_q;

  // Remember whether the accepted command was rejected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         err_q <= 1'b0;
    else if (accept) err_q <= mode_bad;
  end
`else
  assign mode_bad = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = ((len == '0) || mode_bad) ? FIN : ISSUE;
      ISSUE: if (rd_en && rd_last) state_nxt = DRAIN;
      DRAIN: if (wr_last) state_nxt = FIN;
      FIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: read strobe, status; busy includes the accepting cycle.
  always_comb begin
    rd_en = (state == ISSUE) && !pause;
    done  = (state == FIN);
    busy  = (state != IDLE) || accept;
  end

  assign p_addr  = p_base_q + AW'(rd_idx);
  assign s_addr  = s_base_q + AW'(rd_idx);
  assign d_raddr = d_base_q + AW'(rd_idx);
  assign wr_en   = vld[2];
  assign d_waddr = waddr_pipe[2];

  // Command latch plus read index and write counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= '0;
      p_base_q <= '0;
      s_base_q <= '0;
      d_base_q <= '0;
      len_q    <= '0;
      rd_idx   <= '0;
      wr_cnt   <= '0;
    end else if (accept) begin
      mode_q   <= mode;
      p_base_q <= p_base;
      s_base_q <= s_base;
      d_base_q <= d_base;
      len_q    <= len;
      rd_idx   <= '0;
      wr_cnt   <= '0;
    end else begin
      if (rd_en) rd_idx <= rd_idx + LW'(1);
      if (wr_en) wr_cnt <= wr_cnt + LW'(1);
    end
  end

  // Valid/address shift pipe: read cycle -> data capture -> result -> write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld        <= '0;
      waddr_pipe <= '0;
    end else begin
      vld        <= {vld[1:0], rd_en};
      waddr_pipe <= {waddr_pipe[1:0], d_raddr};
    end
  end

  rop3_core #(.N(N)) u_core (
    .clk    (clk),
    .rst    (rst),
    .in_en  (vld[0]),
    .res_en (vld[1]),
    .mode   (mode_q),
    .p_in   (p_rdata),
    .s_in   (s_rdata),
    .d_in   (d_rdata),
    .result (wr_data)
  );

endmodule

// File: tb/tb_rop3_seq.sv
// Directed self-checking bench for rop3_seq with P/S/D SRAM models and an
// event log (reads, writes, done, busy) sampled on the falling edge.
module tb_rop3_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, pause;
  logic [7:0] mode, p_base, s_base, d_base, len;
  logic       rd_en, wr_en, busy, done;
  logic [7:0] p_addr, s_addr, d_raddr, d_waddr;
  logic [3:0] p_rdata, s_rdata, d_rdata, wr_data;
`ifdef ROP3_MODE_CHECK_EN
  logic       err;
`endif

  logic [3:0] mem_p [256];
  logic [3:0] mem_s [256];
  logic [3:0] mem_d [256];

  typedef struct { int cyc; logic [7:0] p; logic [7:0] s; logic [7:0] d; } rd_rec_t;
  typedef struct { int cyc; logic [7:0] a; logic [3:0] w; } wr_rec_t;

  rd_rec_t rd_q[$];
  wr_rec_t wr_q[$];
  int      done_q[$];
  int      err_q[$];
  int      busy_cnt = 0;
  int      cyc = 0;
  int      total = 0;
  int      bad = 0;

  rop3_seq dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .p_base(p_base), .s_base(s_base), .d_base(d_base), .len(len), .pause(pause),
    .rd_en(rd_en), .p_addr(p_addr), .s_addr(s_addr), .d_raddr(d_raddr),
    .p_rdata(p_rdata), .s_rdata(s_rdata), .d_rdata(d_rdata),
    .wr_en(wr_en), .d_waddr(d_waddr), .wr_data(wr_data),
    .busy(busy), .done(done)
`ifdef ROP3_MODE_CHECK_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read SRAM models.
  always @(posedge clk) begin
    if (rd_en) begin
      p_rdata <= mem_p[p_addr];
      s_rdata <= mem_s[s_addr];
      d_rdata <= mem_d[d_raddr];
    end
  end

  // Event log.
  always @(negedge clk) begin
    if (rd_en) rd_q.push_back('{cyc, p_addr, s_addr, d_raddr});
    if (wr_en) wr_q.push_back('{cyc, d_waddr, wr_data});
    if (done)  done_q.push_back(cyc);
    if (busy)  busy_cnt = busy_cnt + 1;
`ifdef ROP3_MODE_CHECK_EN
    if (err)   err_q.push_back(cyc);
`endif
  end

  task automatic start_cmd(input logic [7:0] m, input logic [7:0] pb, input logic [7:0] sb,
                           input logic [7:0] db, input logic [7:0] l, output int sc);
    @(posedge clk); #1;
    mode = m; p_base = pb; s_base = sb; d_base = db; len = l; start = 1'b1;
    sc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget, output logic ok);
    for (int i = 0; i < budget && done_q.size() == base; i++) @(posedge clk);
    ok = (done_q.size() > base);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({rd_en, wr_en, busy, done} !== 4'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0000", {rd_en, wr_en, busy, done});
    end
    total++;
    if ({p_addr, s_addr, d_raddr, d_waddr, wr_data} !== 36'h0) begin
      bad++; $display("FAIL reset_data: got %h want 0", {p_addr, s_addr, d_raddr, d_waddr, wr_data});
    end
`ifdef ROP3_MODE_CHECK_EN
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [3:0] sv [4];
    logic [3:0] dv [4];
    logic [3:0] ev [4];
    int rb, wb, db, bb, sc;
    logic ok;
    sv = '{4'hF, 4'hF, 4'h0, 4'hA};
    dv = '{4'h3, 4'hC, 4'hF, 4'hA};
    ev = '{4'h3, 4'hC, 4'h0, 4'hA};
    for (int k = 0; k < 4; k++) begin
      mem_p[8'h10 + k] = 4'(k + 5); mem_s[8'h20 + k] = sv[k]; mem_d[8'h30 + k] = dv[k];
    end
    rb = rd_q.size(); wb = wr_q.size(); db = done_q.size(); bb = busy_cnt;
    start_cmd(8'h88, 8'h10, 8'h20, 8'h30, 8'd4, sc);
    wait_done(db, 40, ok);
    repeat (4) @(posedge clk);
    total++;
    if (!ok || done_q[db] !== sc + 8) begin
      bad++; $display("FAIL basic_done: got ok=%0b cyc=%0d want cyc=%0d", ok, ok ? done_q[db] - sc : -1, 8);
    end
    total++;
    if (rd_q.size() - rb !== 4) begin bad++; $display("FAIL basic_nrd: got %0d want 4", rd_q.size() - rb); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (rb + k >= rd_q.size() || rd_q[rb + k].p !== 8'(8'h10 + k) || rd_q[rb + k].s !== 8'(8'h20 + k) ||
          rd_q[rb + k].d !== 8'(8'h30 + k) || rd_q[rb + k].cyc !== sc + 1 + k) begin
        bad++; $display("FAIL basic_rd[%0d]: got wrong address/cycle want p=%h at +%0d", k, 8'h10 + k, 1 + k);
      end
    end
    total++;
    if (wr_q.size() - wb !== 4) begin bad++; $display("FAIL basic_nwr: got %0d want 4", wr_q.size() - wb); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (wb + k >= wr_q.size() || wr_q[wb + k].a !== 8'(8'h30 + k) || wr_q[wb + k].w !== ev[k]) begin
        bad++; $display("FAIL basic_wr[%0d]: got a=%h w=%h want a=%h w=%h", k,
                        wr_q[wb + k].a, wr_q[wb + k].w, 8'h30 + k, ev[k]);
      end
    end
    total++;
    if (wr_q[wb].cyc - rd_q[rb].cyc !== 3) begin
      bad++; $display("FAIL basic_latency: got %0d want 3", wr_q[wb].cyc - rd_q[rb].cyc);
    end
    total++;
    if (busy_cnt - bb !== 9) begin bad++; $display("FAIL basic_busy: got %0d want 9", busy_cnt - bb); end
  endtask

  task automatic test_len0();
    int rb, wb, db, bb, sc;
    logic ok;
    rb = rd_q.size(); wb = wr_q.size(); db = done_q.size(); bb = busy_cnt;
    start_cmd(8'hFF, 8'h00, 8'h00, 8'h00, 8'd0, sc);
    wait_done(db, 20, ok);
    repeat (4) @(posedge clk);
    total++;
    if (!ok || done_q[db] !== sc + 1) begin bad++; $display("FAIL len0_done: got ok=%0b want done at +1", ok); end
    total++;
    if (done_q.size() - db !== 1) begin bad++; $display("FAIL len0_ndone: got %0d want 1", done_q.size() - db); end
    total++;
    if (busy_cnt - bb !== 2) begin bad++; $display("FAIL len0_busy: got %0d want 2", busy_cnt - bb); end
    total++;
    if ((rd_q.size() - rb) + (wr_q.size() - wb) !== 0) begin
      bad++; $display("FAIL len0_access: got rd=%0d wr=%0d want 0/0", rd_q.size() - rb, wr_q.size() - wb);
    end
  endtask

  task automatic test_pause();
    logic [3:0] pv [6];
    logic [3:0] dv [6];
    logic [3:0] ev [6];
    int rc [6];
    int rb, wb, db, sc;
    logic ok;
    pv = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
    dv = '{4'hF, 4'hF, 4'h0, 4'h0, 4'hA, 4'h5};
    ev = '{4'hE, 4'hD, 4'h3, 4'h4, 4'hF, 4'h3};
    rc = '{1, 2, 6, 7, 8, 9};
    for (int k = 0; k < 6; k++) begin
      mem_p[8'h40 + k] = pv[k]; mem_s[8'h50 + k] = 4'h9; mem_d[8'h60 + k] = dv[k];
    end
    rb = rd_q.size(); wb = wr_q.size(); db = done_q.size();
    start_cmd(8'h5A, 8'h40, 8'h50, 8'h60, 8'd6, sc);
    @(posedge clk); #1;
    @(posedge clk); #1;
    pause = 1'b1;
    repeat (3) @(posedge clk);
    #1 pause = 1'b0;
    repeat (4) @(posedge clk);
    #1 pause = 1'b1;           // held through DRAIN; must not matter
    wait_done(db, 40, ok);
    pause = 1'b0;
    repeat (4) @(posedge clk);
    total++;
    if (!ok || done_q[db] !== sc + 13) begin
      bad++; $display("FAIL pause_done: got ok=%0b cyc=%0d want 13", ok, ok ? done_q[db] - sc : -1);
    end
    for (int k = 0; k < 6; k++) begin
      total++;
      if (rb + k >= rd_q.size() || rd_q[rb + k].p !== 8'(8'h40 + k) || rd_q[rb + k].cyc !== sc + rc[k]) begin
        bad++; $display("FAIL pause_rd[%0d]: got wrong address/cycle want p=%h at +%0d", k, 8'h40 + k, rc[k]);
      end
      total++;
      if (wb + k >= wr_q.size() || wr_q[wb + k].a !== 8'(8'h60 + k) || wr_q[wb + k].w !== ev[k]) begin
        bad++; $display("FAIL pause_wr[%0d]: got a=%h w=%h want a=%h w=%h", k,
                        wr_q[wb + k].a, wr_q[wb + k].w, 8'h60 + k, ev[k]);
      end
    end
  endtask

  task automatic test_wrap_ignored_start();
    logic [7:0] ea [3];
    logic [3:0] ev [3];
    int rb, wb, db, sc;
    logic ok;
    ea = '{8'hFE, 8'hFF, 8'h00};
    ev = '{4'h7, 4'h8, 4'h9};
    for (int k = 0; k < 3; k++) begin
      mem_s[8'h80 + k] = ev[k]; mem_d[ea[k]] = 4'h1;
    end
    rb = rd_q.size(); wb = wr_q.size(); db = done_q.size();
    start_cmd(8'hCC, 8'h70, 8'h80, 8'hFE, 8'd3, sc);
    @(posedge clk); #1;
    mode = 8'hFF; d_base = 8'h00; len = 8'd5; start = 1'b1;   // arrives while busy
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(db, 40, ok);
    repeat (8) @(posedge clk);
    total++;
    if (!ok || done_q[db] !== sc + 7) begin bad++; $display("FAIL wrap_done: got ok=%0b want done at +7", ok); end
    total++;
    if (done_q.size() - db !== 1 || wr_q.size() - wb !== 3 || rd_q.size() - rb !== 3) begin
      bad++; $display("FAIL ignored_start: got done=%0d wr=%0d rd=%0d want 1/3/3",
                      done_q.size() - db, wr_q.size() - wb, rd_q.size() - rb);
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (rb + k >= rd_q.size() || rd_q[rb + k].d !== ea[k]) begin
        bad++; $display("FAIL wrap_rd[%0d]: got d=%h want %h", k, rd_q[rb + k].d, ea[k]);
      end
      total++;
      if (wb + k >= wr_q.size() || wr_q[wb + k].a !== ea[k] || wr_q[wb + k].w !== ev[k]) begin
        bad++; $display("FAIL wrap_wr[%0d]: got a=%h w=%h want a=%h w=%h", k,
                        wr_q[wb + k].a, wr_q[wb + k].w, ea[k], ev[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int rb, wb, db, sc;
    logic ok;
    for (int k = 0; k < 10; k++) begin
      mem_p[8'hA0 + k] = 4'(k); mem_s[8'hB0 + k] = 4'h0; mem_d[8'hC0 + k] = 4'h0;
    end
    rb = rd_q.size();
    start_cmd(8'hF0, 8'hA0, 8'hB0, 8'hC0, 8'd10, sc);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    total++;
    if ({rd_en, wr_en, busy, done} !== 4'b0) begin
      bad++; $display("FAIL midrst_drop: got %b want 0000", {rd_en, wr_en, busy, done});
    end
    total++;
    if (rd_q.size() - rb !== 4) begin bad++; $display("FAIL midrst_nrd: got %0d want 4", rd_q.size() - rb); end
    rb = rd_q.size(); wb = wr_q.size(); db = done_q.size();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    total++;
    if (rd_q.size() != rb || wr_q.size() != wb || done_q.size() != db) begin
      bad++; $display("FAIL midrst_quiet: got rd=%0d wr=%0d done=%0d want 0/0/0",
                      rd_q.size() - rb, wr_q.size() - wb, done_q.size() - db);
    end
    mem_s[8'h88] = 4'h3; mem_s[8'h89] = 4'h5; mem_d[8'h98] = 4'h6; mem_d[8'h99] = 4'h6;
    start_cmd(8'h66, 8'h00, 8'h88, 8'h98, 8'd2, sc);
    wait_done(db, 30, ok);
    repeat (4) @(posedge clk);
    total++;
    if (!ok || done_q[db] !== sc + 6) begin bad++; $display("FAIL rerun_done: got ok=%0b want done at +6", ok); end
    total++;
    if (wr_q.size() - wb !== 2 || wr_q[wb].a !== 8'h98 || wr_q[wb].w !== 4'h5 ||
        wr_q[wb + 1].a !== 8'h99 || wr_q[wb + 1].w !== 4'h3) begin
      bad++; $display("FAIL rerun_wr: got n=%0d want 98:5 99:3", wr_q.size() - wb);
    end
  endtask

  task automatic test_bad_mode();
    int rb, wb, db, bb, sc;
    logic ok;
    for (int k = 0; k < 3; k++) begin
      mem_p[8'hC0 + k] = 4'hF; mem_s[8'hC4 + k] = 4'hF; mem_d[8'hC8 + k] = 4'h9;
    end
    rb = rd_q.size(); wb = wr_q.size(); db = done_q.size(); bb = busy_cnt;
`ifdef ROP3_MODE_CHECK_EN
    begin
      int eb;
      eb = err_q.size();
      start_cmd(8'h12, 8'hC0, 8'hC4, 8'hC8, 8'd3, sc);
      wait_done(db, 20, ok);
      repeat (4) @(posedge clk);
      total++;
      if (!ok || done_q[db] !== sc + 1) begin bad++; $display("FAIL badmode_done: got ok=%0b want done at +1", ok); end
      total++;
      if (err_q.size() - eb !== 1 || !ok || err_q[eb] !== done_q[db]) begin
        bad++; $display("FAIL badmode_err: got %0d err pulses want 1 with done", err_q.size() - eb);
      end
      total++;
      if (rd_q.size() != rb || wr_q.size() != wb || busy_cnt - bb !== 2) begin
        bad++; $display("FAIL badmode_access: got rd=%0d wr=%0d busy=%0d want 0/0/2",
                        rd_q.size() - rb, wr_q.size() - wb, busy_cnt - bb);
      end
    end
`else
    start_cmd(8'h12, 8'hC0, 8'hC4, 8'hC8, 8'd3, sc);
    wait_done(db, 30, ok);
    repeat (4) @(posedge clk);
    total++;
    if (!ok || done_q[db] !== sc + 7) begin bad++; $display("FAIL badmode_done: got ok=%0b want done at +7", ok); end
    total++;
    if (rd_q.size() - rb !== 3 || wr_q.size() - wb !== 3) begin
      bad++; $display("FAIL badmode_count: got rd=%0d wr=%0d want 3/3", rd_q.size() - rb, wr_q.size() - wb);
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (wb + k >= wr_q.size() || wr_q[wb + k].a !== 8'(8'hC8 + k) || wr_q[wb + k].w !== 4'h0) begin
        bad++; $display("FAIL badmode_wr[%0d]: got a=%h w=%h want a=%h w=0", k,
                        wr_q[wb + k].a, wr_q[wb + k].w, 8'hC8 + k);
      end
    end
`endif
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0;
    mode = '0; p_base = '0; s_base = '0; d_base = '0; len = '0;
    for (int i = 0; i < 256; i++) begin
      mem_p[i] = '0; mem_s[i] = '0; mem_d[i] = '0;
    end
    test_reset();
    test_basic();
    test_len0();
    test_pause();
    test_wrap_ignored_start();
    test_reset_mid();
    test_bad_mode();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
